prime_scan_ctrl: RTL and testbench

Parametrised scan-and-replay controller for the prime-filter datapath. It walks a read-only table of `DEPTH` words of `DATA_W` bits and tests each word for primality with an internal iterative trial-division engine. Each prime is written in order into a single-port RAM. After the scan it replays the stored primes to the seven-segment driver at a programmable rate. It replaces the separate address counter, prime checker, prime/done counters, comparator and FSM with one block, and supports any word width and table depth.

---
 rtl/prime_scan_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_prime_scan_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_scan_ctrl.sv
// Scan-and-replay controller: walks a ROM table and tests each word for primality by trial division.
// Primes are stored densely in a RAM and then replayed to the display at a programmable rate.
module prime_scan_ctrl #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned HOLD_CYC = 50_000_000
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              go,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] disp_data,
  output logic [ADDR_W-1:0] disp_idx,
  output logic [ADDR_W:0]   prime_cnt,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DIV_W  = DATA_W + 1;
  localparam int unsigned SQ_W   = 2 * DATA_W + 2;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_TEST, S_WRITE, S_NEXT, S_REPLAY
  } state_t;

  state_t              r_state,     w_state_nxt;
  logic                r_go_d;
  logic [DATA_W-1:0]   r_n,         w_n_nxt;
  logic [DIV_W-1:0]    r_d,         w_d_nxt;
  logic [DATA_W-1:0]   r_r,         w_r_nxt;
  logic [ADDR_W-1:0]   r_rom_addr,  w_rom_addr_nxt;
  logic [ADDR_W-1:0]   r_ram_addr,  w_ram_addr_nxt;
  logic                r_ram_we,    w_ram_we_nxt;
  logic [DATA_W-1:0]   r_ram_wdata, w_ram_wdata_nxt;
  logic [DATA_W-1:0]   r_disp_data, w_disp_data_nxt;
  logic [ADDR_W-1:0]   r_disp_idx,  w_disp_idx_nxt;
  logic [CNT_W-1:0]    r_prime_cnt, w_prime_cnt_nxt;
  logic                r_busy,      w_busy_nxt;
  logic                r_done,      w_done_nxt;
  logic [HOLD_W-1:0]   r_hold,      w_hold_nxt;

  logic                w_go_edge;
  logic                w_start;
  logic [DIV_W-1:0]    w_d_inc;
  logic [SQ_W-1:0]     w_d_sq;
  logic [CNT_W-1:0]    w_cnt_last;

  assign w_go_edge  = go & ~r_go_d;
  assign w_start    = w_go_edge && ((r_state == S_IDLE) || (r_state == S_REPLAY));
  assign w_d_inc    = r_d + DIV_W'(1);
  assign w_d_sq     = SQ_W'(w_d_inc) * SQ_W'(w_d_inc);
  assign w_cnt_last = r_prime_cnt - CNT_W'(1);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state     <= S_IDLE;
      r_go_d      <= 1'b1;
      r_n         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_rom_addr  <= '0;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_disp_data <= '0;
      r_disp_idx  <= '0;
      r_prime_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_hold      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_go_d      <= go;
      r_n         <= w_n_nxt;
      r_d         <= w_d_nxt;
      r_r         <= w_r_nxt;
      r_rom_addr  <= w_rom_addr_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_we    <= w_ram_we_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_disp_data <= w_disp_data_nxt;
      r_disp_idx  <= w_disp_idx_nxt;
      r_prime_cnt <= w_prime_cnt_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_hold      <= w_hold_nxt;
    end
  end

  // Next-state and next-output logic; ram_we is raised on entry to WRITE so it is high only there
  always_comb begin
    w_state_nxt     = r_state;
    w_n_nxt         = r_n;
    w_d_nxt         = r_d;
    w_r_nxt         = r_r;
    w_rom_addr_nxt  = r_rom_addr;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_we_nxt    = 1'b0;
    w_ram_wdata_nxt = r_ram_wdata;
    w_disp_data_nxt = r_disp_data;
    w_disp_idx_nxt  = r_disp_idx;
    w_prime_cnt_nxt = r_prime_cnt;
    w_busy_nxt      = r_busy;
    w_done_nxt      = r_done;
    w_hold_nxt      = r_hold;

    if (r_busy) begin
      w_disp_data_nxt = rom_data;
      w_disp_idx_nxt  = r_rom_addr;
    end

    if (w_start) begin
      w_prime_cnt_nxt = '0;
      w_rom_addr_nxt  = '0;
      w_busy_nxt      = 1'b1;
      w_done_nxt      = 1'b0;
      w_state_nxt     = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          w_n_nxt = rom_data;
          if ({1'b0, rom_data} < DIV_W'(2)) begin
            w_state_nxt = S_NEXT;
          end else if ({1'b0, rom_data} < DIV_W'(4)) begin
            w_ram_we_nxt    = 1'b1;
            w_ram_addr_nxt  = ADDR_W'(r_prime_cnt);
            w_ram_wdata_nxt = rom_data;
            w_state_nxt     = S_WRITE;
          end else begin
            w_d_nxt     = DIV_W'(2);
            w_r_nxt     = rom_data;
            w_state_nxt = S_TEST;
          end
        end
        S_TEST: begin
          if ({1'b0, r_r} >= r_d) begin
            w_r_nxt = r_r - DATA_W'(r_d);
          end else if (r_r == '0) begin
            w_state_nxt = S_NEXT;
          end else begin
            w_d_nxt = w_d_inc;
            w_r_nxt = r_n;
            if (w_d_sq > SQ_W'(r_n)) begin
              w_ram_we_nxt    = 1'b1;
              w_ram_addr_nxt  = ADDR_W'(r_prime_cnt);
              w_ram_wdata_nxt = r_n;
              w_state_nxt     = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          w_prime_cnt_nxt = r_prime_cnt + CNT_W'(1);
          w_state_nxt     = S_NEXT;
        end
        S_NEXT: begin
          if (r_rom_addr == ADDR_W'(DEPTH - 1)) begin
            w_busy_nxt      = 1'b0;
            w_done_nxt      = 1'b1;
            w_ram_addr_nxt  = '0;
            w_hold_nxt      = '0;
            w_disp_idx_nxt  = '0;
            w_disp_data_nxt = (r_prime_cnt == '0) ? '0 : rom_data;
            w_state_nxt     = S_REPLAY;
          end else begin
            w_rom_addr_nxt = r_rom_addr + ADDR_W'(1);
            w_state_nxt    = S_FETCH;
          end
        end
        S_REPLAY: begin
          // ram_addr doubles as the replay index; an empty result keeps the display frozen at 0
          if (r_prime_cnt != '0) begin
            w_disp_data_nxt = ram_rdata;
            if (r_hold == HOLD_W'(HOLD_CYC - 1)) begin
              w_hold_nxt     = '0;
              w_ram_addr_nxt = ({1'b0, r_ram_addr} == w_cnt_last) ? '0 : r_ram_addr + ADDR_W'(1);
              w_disp_idx_nxt = w_ram_addr_nxt;
            end else begin
              w_hold_nxt = r_hold + HOLD_W'(1);
            end
          end
        end
        S_IDLE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign rom_addr  = r_rom_addr;
  assign ram_addr  = r_ram_addr;
  assign ram_we    = r_ram_we;
  assign ram_wdata = r_ram_wdata;
  assign disp_data = r_disp_data;
  assign disp_idx  = r_disp_idx;
  assign prime_cnt = r_prime_cnt;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Bench for prime_scan_ctrl: a primality/latency model checks an 8-bit instance every cycle,
// and a 10-bit instance covers wide words and reset in the middle of a trial division.
module tb_prime_scan_ctrl;

  localparam int HA = 4;
  localparam int HB = 3;

  logic       clk;
  logic       a_clr_n, a_go;
  logic [3:0] a_rom_addr, a_ram_addr, a_disp_idx;
  logic [7:0] a_rom_data, a_ram_wdata, a_ram_rdata, a_disp_data;
  logic       a_ram_we, a_busy, a_done;
  logic [4:0] a_prime_cnt;
  logic [7:0] a_tbl [16];
  logic [7:0] a_mem [16];

  logic       b_clr_n, b_go;
  logic [1:0] b_rom_addr, b_ram_addr, b_disp_idx;
  logic [9:0] b_rom_data, b_ram_wdata, b_ram_rdata, b_disp_data;
  logic       b_ram_we, b_busy, b_done;
  logic [2:0] b_prime_cnt;
  logic [9:0] b_tbl [4];
  logic [9:0] b_mem [4];
  int         b_wa [$];
  int         b_wd [$];

  int checks = 0;
  int failures = 0;

  prime_scan_ctrl #(.DATA_W(8), .DEPTH(16), .HOLD_CYC(HA)) u_a (
    .clk(clk), .clr_n(a_clr_n), .go(a_go),
    .rom_addr(a_rom_addr), .rom_data(a_rom_data),
    .ram_addr(a_ram_addr), .ram_we(a_ram_we), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata),
    .disp_data(a_disp_data), .disp_idx(a_disp_idx), .prime_cnt(a_prime_cnt),
    .busy(a_busy), .done(a_done)
  );

  prime_scan_ctrl #(.DATA_W(10), .DEPTH(4), .HOLD_CYC(HB)) u_b (
    .clk(clk), .clr_n(b_clr_n), .go(b_go),
    .rom_addr(b_rom_addr), .rom_data(b_rom_data),
    .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
    .disp_data(b_disp_data), .disp_idx(b_disp_idx), .prime_cnt(b_prime_cnt),
    .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROMs and synchronous-read RAMs
  assign a_rom_data = a_tbl[a_rom_addr];
  assign b_rom_data = b_tbl[b_rom_addr];
  always @(posedge clk) begin
    if (a_ram_we) a_mem[a_ram_addr] <= a_ram_wdata;
    a_ram_rdata <= a_mem[a_ram_addr];
    if (b_ram_we) b_mem[b_ram_addr] <= b_ram_wdata;
    b_ram_rdata <= b_mem[b_ram_addr];
  end

  always @(negedge clk) begin
    if (b_clr_n && b_ram_we) begin
      b_wa.push_back(int'(b_ram_addr));
      b_wd.push_back(int'(b_ram_wdata));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k * k <= n; k++) if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Clocks spent on one table entry: fetch + next, plus trial division and a write for primes
  function automatic int entry_cycles(input int n);
    int cyc;
    int d;
    if (n < 2) return 2;
    if (n < 4) return 3;
    cyc = 2;
    d = 2;
    while (d * d <= n) begin
      cyc += n / d + 1;
      if (n % d == 0) return cyc;
      d++;
    end
    return cyc + 1;
  endfunction

  // Reference model and per-cycle comparison for instance A
  int m_primes [16];
  int m_cnt = 0;
  int m_cyc = 0;
  int wr_idx = 0;
  int scan_cyc = 0;
  int rk = 0;
  bit pv_busy = 1'b0;
  bit pv_done = 1'b0;
  int pv_rom_addr = 0;

  always @(negedge clk) begin
    if (!a_clr_n) begin
      pv_busy = 1'b0;
      pv_done = 1'b0;
    end else begin
      check("busy_done_excl", int'(a_busy & a_done), 0);
      if (a_busy && !pv_busy) begin
        m_cnt = 0; m_cyc = 0; wr_idx = 0; scan_cyc = 0;
        for (int i = 0; i < 16; i++) begin
          m_cyc += entry_cycles(int'(a_tbl[i]));
          if (is_prime(int'(a_tbl[i]))) begin
            m_primes[m_cnt] = int'(a_tbl[i]);
            m_cnt++;
          end
        end
        check("scan_start_cnt", int'(a_prime_cnt), 0);
        check("scan_start_addr", int'(a_rom_addr), 0);
      end
      if (a_busy) begin
        scan_cyc++;
        if (pv_busy) begin
          check("scan_disp_idx", int'(a_disp_idx), pv_rom_addr);
          check("scan_disp_data", int'(a_disp_data), int'(a_tbl[pv_rom_addr]));
        end
      end
      if (a_ram_we) begin
        check("we_while_busy", int'(a_busy), 1);
        check("wr_addr", int'(a_ram_addr), wr_idx);
        check("wr_data", int'(a_ram_wdata), (wr_idx < 16) ? m_primes[wr_idx] : -1);
        wr_idx++;
      end
      if (a_done) begin
        if (!pv_done) begin
          rk = 0;
          check("done_at_busy_fall", int'(pv_busy), 1);
          check("scan_cycles", scan_cyc, m_cyc);
          check("prime_cnt", int'(a_prime_cnt), m_cnt);
          check("write_count", wr_idx, m_cnt);
        end else begin
          rk++;
        end
        if (m_cnt == 0) begin
          check("empty_disp_data", int'(a_disp_data), 0);
          check("empty_disp_idx", int'(a_disp_idx), 0);
        end else begin
          check("replay_idx", int'(a_disp_idx), (rk / HA) % m_cnt);
          check("replay_ram_addr", int'(a_ram_addr), (rk / HA) % m_cnt);
          if (rk >= 2) check("replay_data", int'(a_disp_data), m_primes[((rk - 2) / HA) % m_cnt]);
        end
      end
      pv_busy = a_busy;
      pv_done = a_done;
      pv_rom_addr = int'(a_rom_addr);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int which, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && a_done) || (which == 1 && b_done)) return;
    end
    checks++;
    failures++;
    $display("FAIL %s: done not seen within %0d cycles", name, budget);
  endtask

  task automatic a_pulse_go();
    a_go = 1'b1;
    cycles(1);
    check("a_busy_after_edge", int'(a_busy), 1);
    a_go = 1'b0;
  endtask

  int exp6 [6];
  int n0;

  initial begin
    exp6 = '{2, 3, 5, 7, 11, 13};
    a_clr_n = 1'b0; a_go = 1'b1;
    b_clr_n = 1'b0; b_go = 1'b0;
    for (int i = 0; i < 16; i++) begin a_tbl[i] = 8'(i); a_mem[i] = '0; end
    b_tbl = '{10'd1021, 10'd1023, 10'd961, 10'd997};
    for (int i = 0; i < 4; i++) b_mem[i] = '0;
    cycles(3);

    check("rst_rom_addr", int'(a_rom_addr), 0);
    check("rst_ram_addr", int'(a_ram_addr), 0);
    check("rst_ram_we", int'(a_ram_we), 0);
    check("rst_ram_wdata", int'(a_ram_wdata), 0);
    check("rst_disp_data", int'(a_disp_data), 0);
    check("rst_disp_idx", int'(a_disp_idx), 0);
    check("rst_prime_cnt", int'(a_prime_cnt), 0);
    check("rst_busy", int'(a_busy), 0);
    check("rst_done", int'(a_done), 0);

    // go held high through reset must not start a scan
    a_clr_n = 1'b1; b_clr_n = 1'b1;
    cycles(5);
    check("go_held_no_start", int'(a_busy), 0);
    check("go_held_no_done", int'(a_done), 0);
    a_go = 1'b0;
    cycles(2);

    // Table 0..15, with go toggled while the scan is busy
    a_pulse_go();
    cycles(3); a_go = 1'b1; cycles(2); a_go = 1'b0; cycles(3); a_go = 1'b1; cycles(1); a_go = 1'b0;
    wait_done(0, 20000, "a_scan_0_15");
    check("lit_prime_cnt_6", int'(a_prime_cnt), 6);
    for (int i = 0; i < 6; i++) check("lit_ram_word", int'(a_mem[i]), exp6[i]);
    cycles(40);

    // go edge during replay restarts the scan with a cleared count
    a_go = 1'b1;
    cycles(1);
    check("restart_busy", int'(a_busy), 1);
    check("restart_done", int'(a_done), 0);
    check("restart_cnt_clear", int'(a_prime_cnt), 0);
    a_go = 1'b0;
    wait_done(0, 20000, "a_rescan");
    check("lit_rescan_cnt", int'(a_prime_cnt), 6);
    cycles(10);

    // All-even table: no primes, frozen display
    for (int i = 0; i < 16; i++) a_tbl[i] = 8'(2 * $urandom_range(2, 127));
    a_pulse_go();
    wait_done(0, 30000, "a_even");
    check("lit_even_cnt", int'(a_prime_cnt), 0);
    cycles(12);

    // Random tables
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 16; i++) a_tbl[i] = 8'($urandom_range(0, 255));
      a_pulse_go();
      wait_done(0, 30000, "a_random");
      cycles(70);
    end

    // Wide instance: 1021 and 997 prime, 1023 = 3*341 and 961 = 31*31 rejected
    b_go = 1'b1; cycles(2); b_go = 1'b0;
    wait_done(1, 20000, "b_scan1");
    check("b_prime_cnt", int'(b_prime_cnt), 2);
    check("b_write_count", b_wa.size(), 2);
    if (b_wa.size() >= 2) begin
      check("b_wr0_addr", b_wa[0], 0);
      check("b_wr0_data", b_wd[0], 1021);
      check("b_wr1_addr", b_wa[1], 1);
      check("b_wr1_data", b_wd[1], 997);
    end
    cycles(2);
    check("b_replay_k2_data", int'(b_disp_data), 1021);
    cycles(3);
    check("b_replay_k5_data", int'(b_disp_data), 997);
    check("b_replay_k5_idx", int'(b_disp_idx), 1);
    cycles(1);
    check("b_replay_wrap_idx", int'(b_disp_idx), 0);

    // Reset in the middle of testing 1021
    b_go = 1'b1;
    cycles(1);
    check("b_busy_after_edge", int'(b_busy), 1);
    b_go = 1'b0;
    cycles(20);
    check("b_in_test_addr", int'(b_rom_addr), 0);
    check("b_in_test_busy", int'(b_busy), 1);
    b_clr_n = 1'b0;
    cycles(1);
    check("b_rst_rom_addr", int'(b_rom_addr), 0);
    check("b_rst_ram_addr", int'(b_ram_addr), 0);
    check("b_rst_ram_we", int'(b_ram_we), 0);
    check("b_rst_ram_wdata", int'(b_ram_wdata), 0);
    check("b_rst_disp_data", int'(b_disp_data), 0);
    check("b_rst_disp_idx", int'(b_disp_idx), 0);
    check("b_rst_prime_cnt", int'(b_prime_cnt), 0);
    check("b_rst_busy", int'(b_busy), 0);
    check("b_rst_done", int'(b_done), 0);
    n0 = b_wa.size();
    b_clr_n = 1'b1;
    cycles(10);
    check("b_no_write_after_rst", b_wa.size(), n0);
    check("b_idle_after_rst", int'(b_busy), 0);
    b_go = 1'b1;
    cycles(1);
    check("b_rescan_busy", int'(b_busy), 1);
    check("b_rescan_addr", int'(b_rom_addr), 0);
    b_go = 1'b0;
    wait_done(1, 20000, "b_scan2");
    check("b_rescan_cnt", int'(b_prime_cnt), 2);
    check("b_rescan_writes", b_wa.size(), n0 + 2);
    if (b_wa.size() >= n0 + 2) begin
      check("b_rescan_wr0", b_wd[n0], 1021);
      check("b_rescan_wr1", b_wd[n0 + 1], 997);
    end
    cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
